// File: rtl/jtkcpu_stack_seq_pkg.sv
// Shared definitions for the push/pull stack sequencer: state encodings
// and register-mask bit positions.
package jtkcpu_stack_seq_pkg;

  typedef enum logic [2:0] {
    STK_IDLE,
    STK_PSH_DEC,
    STK_PSH_WR,
    STK_PUL_RD,
    STK_PUL_INC,
    STK_DONE
  } stk_state_t;

  localparam int unsigned STK_PC = 7;
  localparam int unsigned STK_US = 6;
  localparam int unsigned STK_Y  = 5;
  localparam int unsigned STK_X  = 4;
  localparam int unsigned STK_DP = 3;
  localparam int unsigned STK_B  = 2;
  localparam int unsigned STK_A  = 1;
  localparam int unsigned STK_CC = 0;

  // Registers transferred as two bytes
  localparam logic [7:0] STK_WIDE_MASK = (8'd1 << STK_PC) | (8'd1 << STK_US) |
                                         (8'd1 << STK_Y)  | (8'd1 << STK_X);

  localparam logic [3:0] STK_MAX_BYTES = 4'd12;

endpackage

// File: rtl/jtkcpu_stack_pri.sv
// Picks the highest (push) or lowest (pull) set bit of a register mask and
// flags whether the picked register is 16 bits wide.
module jtkcpu_stack_pri
  import jtkcpu_stack_seq_pkg::*;
(
  input  logic [7:0] sel,
  input  logic       lowest,
  output logic [7:0] pick,
  output logic       is16
);

  // Later loop iterations overwrite earlier ones, so scan order sets priority
  always_comb begin
    pick = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (lowest) begin
        if (sel[3'(7 - i)]) begin
          pick = '0;
          pick[3'(7 - i)] = 1'b1;
        end
      end else if (sel[3'(i)]) begin
        pick = '0;
        pick[3'(i)] = 1'b1;
      end
    end
  end

  assign is16 = |(pick & STK_WIDE_MASK);

endmodule

// File: rtl/jtkcpu_stack_seq.sv
// Push/pull sequencer: expands a register mask into per-byte pointer,
// memory and register-file strobes.
module jtkcpu_stack_seq
  import jtkcpu_stack_seq_pkg::*;
#(
  parameter bit WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       start_psh,
  input  logic       start_pul,
  input  logic [7:0] mask,
  input  logic       ussel,
  input  logic       mem_wait,
  output logic [7:0] psh_sel,
  output logic       psh_hihalf,
  output logic       psh_ussel,
  output logic       psh_dec,
  output logic       pul_en,
  output logic       stack_busy,
  output logic       mem_we,
  output logic       mem_rd,
  output logic       busy,
  output logic       done,
  output logic       pc_pulled,
  output logic [3:0] byte_cnt
);

  stk_state_t state;
  logic       dir_pul;
  logic       idle;
  logic       wait_eff;
  logic       start_any;
  logic [7:0] cur_in;
  logic       cur_lowest;
  logic [7:0] cur_pick;
  logic       cur_is16;
  logic [7:0] rem;
  logic [7:0] nxt_pick;
  logic       nxt_is16;
  logic       more;
  logic [3:0] cnt_next;

  assign idle      = (state == STK_IDLE);
  assign wait_eff  = WAIT_EN & mem_wait;
  assign start_any = start_psh | start_pul;

  // In IDLE the picker looks at the incoming mask so the first pull byte's
  // half can be decided at accept time
  assign cur_in     = idle ? mask : psh_sel;
  assign cur_lowest = idle ? ~start_psh : dir_pul;

  jtkcpu_stack_pri u_cur (
    .sel    (cur_in),
    .lowest (cur_lowest),
    .pick   (cur_pick),
    .is16   (cur_is16)
  );

  assign rem = psh_sel & ~cur_pick;

  jtkcpu_stack_pri u_nxt (
    .sel    (rem),
    .lowest (dir_pul),
    .pick   (nxt_pick),
    .is16   (nxt_is16)
  );

  assign more     = |nxt_pick;
  assign cnt_next = (byte_cnt == STK_MAX_BYTES) ? byte_cnt : byte_cnt + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= STK_IDLE;
      dir_pul    <= 1'b0;
      psh_sel    <= '0;
      psh_hihalf <= 1'b0;
      psh_ussel  <= 1'b0;
      pc_pulled  <= 1'b0;
      byte_cnt   <= '0;
    end else if (cen) begin
      case (state)
        STK_IDLE: begin
          if (start_any) begin
            psh_sel    <= mask;
            psh_ussel  <= ussel;
            byte_cnt   <= '0;
            pc_pulled  <= 1'b0;
            dir_pul    <= ~start_psh;
            psh_hihalf <= start_psh ? 1'b0 : cur_is16;
            if (mask == '0)
              state <= STK_DONE;
            else if (start_psh)
              state <= STK_PSH_DEC;
            else
              state <= STK_PUL_RD;
          end
        end
        STK_PSH_DEC: state <= STK_PSH_WR;
        STK_PSH_WR: begin
          if (!wait_eff) begin
            byte_cnt <= cnt_next;
            if (cur_is16 && !psh_hihalf) begin
              psh_hihalf <= 1'b1;
              state      <= STK_PSH_DEC;
            end else begin
              psh_sel    <= rem;
              psh_hihalf <= 1'b0;
              state      <= more ? STK_PSH_DEC : STK_DONE;
            end
          end
        end
        STK_PUL_RD: begin
          if (!wait_eff)
            state <= STK_PUL_INC;
        end
        STK_PUL_INC: begin
          byte_cnt <= cnt_next;
          if (cur_is16 && psh_hihalf) begin
            psh_hihalf <= 1'b0;
            state      <= STK_PUL_RD;
          end else begin
            psh_sel    <= rem;
            psh_hihalf <= nxt_is16;
            if (cur_pick[STK_PC])
              pc_pulled <= 1'b1;
            state <= more ? STK_PUL_RD : STK_DONE;
          end
        end
        STK_DONE: state <= STK_IDLE;
        default:  state <= STK_IDLE;
      endcase
    end
  end

  always_comb begin
    psh_dec    = 1'b0;
    mem_we     = 1'b0;
    pul_en     = 1'b0;
    mem_rd     = 1'b0;
    stack_busy = 1'b0;
    done       = 1'b0;
    busy       = 1'b0;
    case (state)
      STK_PSH_DEC: begin psh_dec = 1'b1; busy = 1'b1; end
      STK_PSH_WR:  begin mem_we  = 1'b1; busy = 1'b1; end
      STK_PUL_RD:  begin pul_en  = 1'b1; mem_rd = 1'b1; busy = 1'b1; end
      STK_PUL_INC: begin stack_busy = 1'b1; busy = 1'b1; end
      STK_DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jtkcpu_stack_seq.sv
// Directed bench for jtkcpu_stack_seq; observation word is
// {psh_dec, mem_we, pul_en, mem_rd, stack_busy, done, busy, psh_hihalf, psh_sel}.
module tb_jtkcpu_stack_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic       start_psh = 1'b0;
  logic       start_pul = 1'b0;
  logic [7:0] mask = '0;
  logic       ussel = 1'b0;
  logic       mem_wait = 1'b0;
  logic [7:0] psh_sel;
  logic       psh_hihalf, psh_ussel, psh_dec, pul_en, stack_busy;
  logic       mem_we, mem_rd, busy, done, pc_pulled;
  logic [3:0] byte_cnt;

  int errors = 0;
  int checks = 0;

  jtkcpu_stack_seq #(.WAIT_EN(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .start_psh  (start_psh),
    .start_pul  (start_pul),
    .mask       (mask),
    .ussel      (ussel),
    .mem_wait   (mem_wait),
    .psh_sel    (psh_sel),
    .psh_hihalf (psh_hihalf),
    .psh_ussel  (psh_ussel),
    .psh_dec    (psh_dec),
    .pul_en     (pul_en),
    .stack_busy (stack_busy),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd),
    .busy       (busy),
    .done       (done),
    .pc_pulled  (pc_pulled),
    .byte_cnt   (byte_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] obs();
    return {psh_dec, mem_we, pul_en, mem_rd, stack_busy, done, busy, psh_hihalf, psh_sel};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (obs() !== 16'h0000) begin
      errors++; $display("FAIL reset_obs: got %h want %h", obs(), 16'h0000);
    end
    checks++;
    if ({pc_pulled, psh_ussel, byte_cnt} !== 6'd0) begin
      errors++; $display("FAIL reset_regs: got %b want %b", {pc_pulled, psh_ussel, byte_cnt}, 6'd0);
    end
    rst = 1'b0;
    step();
    checks++;
    if (obs() !== 16'h0000) begin
      errors++; $display("FAIL idle_obs: got %h want %h", obs(), 16'h0000);
    end
  endtask

  task automatic test_push_ab();
    logic [15:0] want [5];
    want = '{16'h8206, 16'h4206, 16'h8202, 16'h4202, 16'h0400};
    mask = 8'h06; ussel = 1'b0; start_psh = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      start_psh = 1'b0;
      checks++;
      if (obs() !== want[i]) begin
        errors++; $display("FAIL push_ab c%0d: got %h want %h", i + 1, obs(), want[i]);
      end
    end
    checks++;
    if (byte_cnt !== 4'd2) begin
      errors++; $display("FAIL push_ab_cnt: got %0d want 2", byte_cnt);
    end
    checks++;
    if (psh_ussel !== 1'b0) begin
      errors++; $display("FAIL push_ab_ussel: got %b want 0", psh_ussel);
    end
    step();
  endtask

  task automatic test_push_pc();
    logic [15:0] want [5];
    want = '{16'h8280, 16'h4280, 16'h8380, 16'h4380, 16'h0400};
    mask = 8'h80; ussel = 1'b1; start_psh = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      start_psh = 1'b0;
      checks++;
      if (obs() !== want[i]) begin
        errors++; $display("FAIL push_pc c%0d: got %h want %h", i + 1, obs(), want[i]);
      end
    end
    checks++;
    if ({psh_ussel, byte_cnt} !== 5'b1_0010) begin
      errors++; $display("FAIL push_pc_regs: got %b want %b", {psh_ussel, byte_cnt}, 5'b1_0010);
    end
    ussel = 1'b0;
    step();
  endtask

  task automatic test_pull_cc_pc();
    logic [15:0] want [7];
    want = '{16'h3281, 16'h0A81, 16'h3380, 16'h0B80, 16'h3280, 16'h0A80, 16'h0400};
    mask = 8'h81; start_pul = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      start_pul = 1'b0;
      checks++;
      if (obs() !== want[i]) begin
        errors++; $display("FAIL pull_81 c%0d: got %h want %h", i + 1, obs(), want[i]);
      end
    end
    checks++;
    if ({pc_pulled, byte_cnt} !== 5'b1_0011) begin
      errors++; $display("FAIL pull_81_regs: got %b want %b", {pc_pulled, byte_cnt}, 5'b1_0011);
    end
    step();
  endtask

  task automatic test_mem_wait();
    logic [15:0] want [8];
    want = '{16'h8210, 16'h4210, 16'h4210, 16'h4210, 16'h4210, 16'h8310, 16'h4310, 16'h0400};
    mask = 8'h10; start_psh = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      start_psh = 1'b0;
      checks++;
      if (obs() !== want[i]) begin
        errors++; $display("FAIL wait_x c%0d: got %h want %h", i + 1, obs(), want[i]);
      end
      mem_wait = (i <= 3);
    end
    mem_wait = 1'b0;
    checks++;
    if (byte_cnt !== 4'd2) begin
      errors++; $display("FAIL wait_x_cnt: got %0d want 2", byte_cnt);
    end
    step();
  endtask

  task automatic test_empty_and_both();
    logic [15:0] want [3];
    mask = 8'h00; start_pul = 1'b1;
    step();
    start_pul = 1'b0;
    checks++;
    if ({obs(), byte_cnt} !== {16'h0400, 4'd0}) begin
      errors++; $display("FAIL empty_pull: got %h want %h", {obs(), byte_cnt}, {16'h0400, 4'd0});
    end
    step();
    checks++;
    if (obs() !== 16'h0000) begin
      errors++; $display("FAIL empty_idle: got %h want %h", obs(), 16'h0000);
    end
    want = '{16'h8201, 16'h4201, 16'h0400};
    mask = 8'h01; start_psh = 1'b1; start_pul = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      start_psh = 1'b0; start_pul = 1'b0;
      checks++;
      if (obs() !== want[i]) begin
        errors++; $display("FAIL both_start c%0d: got %h want %h", i + 1, obs(), want[i]);
      end
    end
    checks++;
    if (byte_cnt !== 4'd1) begin
      errors++; $display("FAIL both_start_cnt: got %0d want 1", byte_cnt);
    end
    step();
  endtask

  task automatic test_cen();
    logic [15:0] want [5];
    want = '{16'h8201, 16'h8201, 16'h8201, 16'h4201, 16'h0400};
    mask = 8'h01; start_psh = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      start_psh = 1'b0;
      checks++;
      if (obs() !== want[i]) begin
        errors++; $display("FAIL cen_hold c%0d: got %h want %h", i + 1, obs(), want[i]);
      end
      cen = !(i == 0 || i == 1);
    end
    cen = 1'b1;
    step();
  endtask

  task automatic test_full(input logic pul);
    int n = 0, xfer = 0, ptr = 0;
    mask = 8'hFF;
    start_psh = ~pul; start_pul = pul;
    for (int i = 0; i < 40; i++) begin
      step();
      start_psh = 1'b0; start_pul = 1'b0;
      n++;
      if (pul ? pul_en : mem_we) xfer++;
      if (pul ? stack_busy : psh_dec) ptr++;
      if (done) break;
    end
    checks++;
    if ({n, xfer, ptr} !== {32'd25, 32'd12, 32'd12}) begin
      errors++; $display("FAIL full_ff pul=%0b: got len=%0d xfer=%0d ptr=%0d want 25 12 12", pul, n, xfer, ptr);
    end
    checks++;
    if ({pc_pulled, byte_cnt} !== {pul, 4'd12}) begin
      errors++; $display("FAIL full_ff_regs pul=%0b: got %b want %b", pul, {pc_pulled, byte_cnt}, {pul, 4'd12});
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [15:0] want [7];
    logic [15:0] want2 [3];
    want = '{16'h82FF, 16'h42FF, 16'h83FF, 16'h43FF, 16'h827F, 16'h427F, 16'h837F};
    mask = 8'hFF; ussel = 1'b1; start_psh = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      start_psh = 1'b0;
      checks++;
      if (obs() !== want[i]) begin
        errors++; $display("FAIL push_ff c%0d: got %h want %h", i + 1, obs(), want[i]);
      end
    end
    checks++;
    if (byte_cnt !== 4'd3) begin
      errors++; $display("FAIL push_ff_cnt: got %0d want 3", byte_cnt);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({obs(), psh_ussel, pc_pulled, byte_cnt} !== 22'd0) begin
      errors++; $display("FAIL reset_mid: got %h want 0", {obs(), psh_ussel, pc_pulled, byte_cnt});
    end
    ussel = 1'b0;
    step();
    rst = 1'b0;
    step();
    want2 = '{16'h3202, 16'h0A02, 16'h0400};
    mask = 8'h02; start_pul = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      start_pul = 1'b0;
      checks++;
      if (obs() !== want2[i]) begin
        errors++; $display("FAIL pull_a c%0d: got %h want %h", i + 1, obs(), want2[i]);
      end
    end
    checks++;
    if ({pc_pulled, byte_cnt} !== 5'b0_0001) begin
      errors++; $display("FAIL pull_a_regs: got %b want %b", {pc_pulled, byte_cnt}, 5'b0_0001);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_push_ab();
    test_push_pc();
    test_pull_cc_pc();
    test_mem_wait();
    test_empty_and_both();
    test_cen();
    test_full(1'b0);
    test_full(1'b1);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
